// File: rtl/elevator_pkg.sv
// Shared definitions for the three-floor elevator: motor commands, floor codes,
// scheduler states and floor bit-mask helpers.
package elevator_pkg;

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_UP   = 2'b01;
    localparam logic [1:0] MOTOR_DOWN = 2'b10;

    localparam logic [1:0] FLOOR0     = 2'd0;
    localparam logic [1:0] FLOOR1     = 2'd1;
    localparam logic [1:0] FLOOR2     = 2'd2;
    localparam logic [1:0] FLOOR_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVING,
        ST_DOOR_OPEN,
        ST_DOOR_CLOSING
    } state_t;

    function automatic logic [2:0] floor_mask(input logic [1:0] f);
        case (f)
            FLOOR0:  return 3'b001;
            FLOOR1:  return 3'b010;
            FLOOR2:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] above_mask(input logic [1:0] f);
        case (f)
            FLOOR0:  return 3'b110;
            FLOOR1:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] below_mask(input logic [1:0] f);
        case (f)
            FLOOR1:  return 3'b001;
            FLOOR2:  return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/door_hold_timer.sv
// Door hold timer: down-counter of tick pulses, reloaded on load/restart,
// frozen on request; done pulses on the tick that reaches terminal count.
module door_hold_timer #(
    parameter int unsigned DOOR_HOLD_TICKS = 5
) (
    input  logic clk,
    input  logic reset0,
    input  logic load,
    input  logic run,
    input  logic tick,
    input  logic freeze,
    output logic done
);

    localparam int CW = $clog2(DOOR_HOLD_TICKS + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DOOR_HOLD_TICKS);

    if (DOOR_HOLD_TICKS < 1) begin : g_bad_hold
        $error("door_hold_timer needs DOOR_HOLD_TICKS >= 1");
    end

    logic [CW-1:0] count;
    logic          step;

    // A load cycle never consumes a tick, so entry and restart ticks are ignored.
    assign step = run && tick && !freeze && !load && (count != '0);
    assign done = step && (count == CW'(1));

    always_ff @(posedge clk) begin
        if (reset0) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (step) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// Three-floor call scheduler: call latch, direction-preserving sweep, door and
// motor sequencing. Optional feature macro: OVERLOAD_HOLD_EN (overload holds door).
//
// state            | meaning
// -----------------+------------------------------------------------------
// ST_IDLE          | no motion; homes downward if between floors
// ST_MOVING        | motor running in dir_up direction toward a call
// ST_DOOR_OPEN     | door open at door_floor, hold timer running
// ST_DOOR_CLOSING  | door commanded shut, waiting for door_closed
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DOOR_HOLD_TICKS = 5,
    parameter int unsigned N_FLOORS        = 3
) (
    input  logic       clk,
    input  logic       reset0,
    input  logic       tick,
    input  logic [2:0] cab_req,
    input  logic [2:0] hall_req,
    input  logic [1:0] at_floor,
    input  logic       door_closed,
    input  logic       overload,
    output logic [1:0] motor_cmd,
    output logic       door_open,
    output logic [2:0] pending,
    output logic       dir_up,
    output logic       busy
);

    if (N_FLOORS != 3) begin : g_bad_floors
        $error("call_scheduler supports exactly 3 floors");
    end

    state_t     state, state_next, eval_state;
    logic [1:0] door_floor, here;
    logic       entry;
    logic [2:0] req, ahead, behind, clr;
    logic       at_here, here_req, over;
    logic       dir_next, eval_dir;
    logic [1:0] motor_sel, eval_motor, motor_next;
    logic       hold_load, hold_done;

`ifdef OVERLOAD_HOLD_EN
    assign over = overload;
`else
    logic unused_overload;
    assign unused_overload = overload;
    assign over = 1'b0;
`endif

    assign req      = cab_req | hall_req;
    assign here     = (state == ST_DOOR_OPEN || state == ST_DOOR_CLOSING) ? door_floor : at_floor;
    assign at_here  = |(pending & floor_mask(here));
    assign here_req = |(req & floor_mask(here));
    assign ahead    = pending & (dir_up ? above_mask(here) : below_mask(here));
    assign behind   = pending & (dir_up ? below_mask(here) : above_mask(here));

    // Shared decision used from IDLE and after the door finishes closing.
    always_comb begin
        eval_state = ST_IDLE;
        eval_dir   = dir_up;
        eval_motor = MOTOR_STOP;
        if (here == FLOOR_NONE) begin
            eval_motor = MOTOR_DOWN;
        end else if (at_here) begin
            eval_state = ST_DOOR_OPEN;
        end else if (|ahead) begin
            eval_state = ST_MOVING;
            eval_motor = dir_up ? MOTOR_UP : MOTOR_DOWN;
        end else if (|behind) begin
            eval_state = ST_MOVING;
            eval_dir   = !dir_up;
            eval_motor = dir_up ? MOTOR_DOWN : MOTOR_UP;
        end
    end

    always_comb begin
        state_next = state;
        dir_next   = dir_up;
        motor_sel  = MOTOR_STOP;
        hold_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = eval_state;
                dir_next   = eval_dir;
                motor_sel  = eval_motor;
            end
            ST_MOVING: begin
                motor_sel = dir_up ? MOTOR_UP : MOTOR_DOWN;
                if (at_here) begin
                    state_next = ST_DOOR_OPEN;
                end else if ((dir_up && here == FLOOR2) || (!dir_up && here == FLOOR0)) begin
                    state_next = ST_IDLE;
                    motor_sel  = MOTOR_STOP;
                end
            end
            ST_DOOR_OPEN: begin
                if (here_req || entry) begin
                    hold_load = 1'b1;
                end else if (hold_done) begin
                    state_next = ST_DOOR_CLOSING;
                end
            end
            ST_DOOR_CLOSING: begin
                if (here_req || over) begin
                    state_next = ST_DOOR_OPEN;
                end else if (door_closed) begin
                    state_next = eval_state;
                    dir_next   = eval_dir;
                    motor_sel  = eval_motor;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The floor being served drops its call; a coincident request for it is absorbed.
    assign clr        = (state_next == ST_DOOR_OPEN) ? floor_mask(here) : 3'b000;
    assign motor_next = (door_closed && state_next != ST_DOOR_OPEN) ? motor_sel : MOTOR_STOP;

    door_hold_timer #(
        .DOOR_HOLD_TICKS(DOOR_HOLD_TICKS)
    ) u_hold (
        .clk    (clk),
        .reset0 (reset0),
        .load   (hold_load),
        .run    (state == ST_DOOR_OPEN),
        .tick   (tick),
        .freeze (over),
        .done   (hold_done)
    );

    always_ff @(posedge clk) begin
        if (reset0) begin
            state      <= ST_IDLE;
            motor_cmd  <= MOTOR_STOP;
            door_open  <= 1'b0;
            pending    <= 3'b000;
            dir_up     <= 1'b1;
            busy       <= 1'b0;
            door_floor <= FLOOR0;
            entry      <= 1'b0;
        end else begin
            state     <= state_next;
            motor_cmd <= motor_next;
            door_open <= (state_next == ST_DOOR_OPEN);
            pending   <= (pending | req) & ~clr;
            dir_up    <= dir_next;
            busy      <= (state_next != ST_IDLE);
            entry     <= (state_next == ST_DOOR_OPEN) && (state != ST_DOOR_OPEN);
            if (state_next == ST_DOOR_OPEN) begin
                door_floor <= here;
            end
        end
    end

endmodule
